// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: RV32I load/store controller with read-modify-write sub-word stores; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module lsu_dmem_ctrl #(
    parameter int MEM_AW    = 10,
    parameter int MEM_DEPTH = 1001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [31:0]       mem_read_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wd_q, wd_d;
    logic              ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [31:0]       rdata_q, rdata_d, wdat_q, wdat_d;
    logic [MEM_AW-1:0] maddr_q, maddr_d;
    logic              accept, illegal, range_bad, mis, bad;
    logic [7:0]        by;
    logic [15:0]       hw;
    logic [31:0]       ext, mask, lane, merged;
    assign accept    = state_q == IDLE && req;
    assign illegal   = we ? (funct3[2] || funct3[1:0] == 2'b11)
                          : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
    assign range_bad = {2'b00, addr[31:2]} >= $unsigned(MEM_DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign bad = illegal || range_bad || mis;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            wd_q    <= 16'h0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
            wdat_q  <= 32'h0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            wd_q    <= wd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            wdat_q  <= wdat_d;
            maddr_q <= maddr_d;
        end
    end
    always_comb begin
        state_d = state_q == IDLE ? (!req ? IDLE : bad ? DONE : (we && funct3[1:0] == 2'b10) ? WR : RD)
                : state_q == RD   ? (we_q ? WR : DONE)
                : state_q == WR   ? DONE : IDLE;
    end
    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        by      = mem_read_data[{off_q, 3'b000} +: 8];
        hw      = mem_read_data[{off_q[1], 4'b0000} +: 16];
        ext     = f3_q[1] ? mem_read_data
                : f3_q[0] ? {{16{~f3_q[2] & hw[15]}}, hw} : {{24{~f3_q[2] & by[7]}}, by};
        mask    = f3_q[0] ? 32'h0000_FFFF << {off_q[1], 4'b0000} : 32'h0000_00FF << {off_q, 3'b000};
        lane    = f3_q[0] ? {2{wd_q}} : {4{wd_q[7:0]}};
        merged  = (mem_read_data & ~mask) | (lane & mask);
        we_d    = accept ? we : we_q;
        f3_d    = accept ? funct3 : f3_q;
        off_d   = accept ? addr[1:0] : off_q;
        wd_d    = accept ? wdata[15:0] : wd_q;
        maddr_d = accept ? addr[MEM_AW+1:2] : maddr_q;
        ready_d = state_d == IDLE;
        done_d  = state_d == DONE;
        err_d   = accept && bad;
        rd_d    = state_d == RD;
        wr_d    = state_d == WR;
        wdat_d  = (accept && we && funct3 == 3'b010) ? wdata : (state_q == RD && we_q) ? merged : wdat_q;
        rdata_d = (state_q == RD && !we_q) ? ext : rdata_q;
    end
    assign ready          = ready_q;
    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign mem_addr       = maddr_q;
    assign mem_write_data = wdat_q;
    assign mem_memwrite   = wr_q;
    assign mem_memread    = rd_q;
endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store controller sitting between the RV32I execute stage and the word-organised data memory. Accepts one load or store per handshake and drives the memory's `addr`/`write_data`/`memwrite`/`memread` port. Sub-word stores are performed as read-modify-write, since the memory has no byte enables. Loads are returned aligned and sign/zero-extended per funct3.

## Interface
- `MEM_AW`, 10: memory word-address width.
- `MEM_DEPTH`, 1001: number of valid memory words; word indices ≥ `MEM_DEPTH` are out of range.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  1: core request; sampled only while `ready`=1.
- `we`  in  1: 1 = store, 0 = load.
- `funct3`  in  3: RV32I size/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, right-aligned.
- `ready`  out  1: controller idle, can accept `req`.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid with `done`; access rejected, no memory write occurred.
- `rdata`  out  32: load result; held from `done` until the next `done`.
- `mem_addr`  out  `MEM_AW`: word address, `addr[MEM_AW+1:2]`.
- `mem_write_data`  out  32: merged word to write.
- `mem_memwrite`  out  1: memory write strobe.
- `mem_memread`  out  1: memory read strobe.
- `mem_read_data`  in  32: memory read word.

## Operation
- FSM states: IDLE, RD, WR, DONE. All outputs registered.
- IDLE: `ready`=1. On `req`, latch `we`, `funct3`, `addr`, `wdata`; classify:
  - illegal funct3 (load 011/110/111, store ≥ 011), or word index ≥ `MEM_DEPTH` → DONE with `err`=1.
  - load, any size → RD.
  - SW → WR; `mem_write_data` = `wdata`.
  - SB/SH → RD, then WR.
- RD: `mem_memread`=1 for exactly one cycle; `mem_read_data` is captured at the end of that cycle.
  - Load → DONE. Extract a byte at `addr[1:0]`*8, or a halfword at `addr[1]`*16. Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
  - SB/SH → WR. Replace only the addressed byte/halfword lane of the captured word with `wdata[7:0]`/`wdata[15:0]`; other lanes keep the captured values.
- WR: `mem_memwrite`=1 for exactly one cycle with stable `mem_addr`/`mem_write_data` → DONE.
- DONE: `done`=1 for one cycle, `err` valid, `rdata` updated for loads only → IDLE.
- `mem_memread` and `mem_memwrite` are never high in the same cycle. `mem_addr` is held constant across RD and WR of one access.
- `err` accesses never assert either memory strobe.
- `rdata` is unchanged by stores and by errored loads.

## Timing
- Reset (async assert, sync release): state IDLE; `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_addr`=0, `mem_write_data`=0, `mem_memwrite`=0, `mem_memread`=0.
- Reset asserted mid-access drops all strobes immediately. An interrupted RMW may leave memory unmodified but never partially written.
- Latency from the `req` edge to the `done` cycle:
  - load: 2 cycles (RD, DONE);
  - SW: 2 cycles (WR, DONE);
  - SB/SH: 3 cycles (RD, WR, DONE);
  - error: 1 cycle (DONE).
- `ready`=0 from the cycle after acceptance until returning to IDLE. A `req` held high during DONE is accepted on the following IDLE cycle; there is no back-to-back acceptance in DONE.
- Input changes while `ready`=0 are ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, goes to DONE with `err`=1 and no memory access.
- Undefined: misaligned addresses are silently forced aligned: halfword uses `addr[1]` and ignores `addr[0]`; word ignores `addr[1:0]`. `err` is never raised for alignment.

## Test plan
- Reset values: after reset, SW addr 0x10 wdata 0xDEADBEEF → WR strobe at `mem_addr`=4, `done` 2 cycles after `req`, `err`=0.
- Sign extension: memory word 4 = 0x80FF7F01.
  - LB addr 0x12 → `rdata`=0xFFFFFFFF.
  - LBU addr 0x13 → 0x00000080.
  - LH addr 0x10 → 0x00007F01.
  - LHU addr 0x12 → 0x000080FF.
- RMW: word 4 = 0x11223344, SB addr 0x11 wdata 0xAA → one RD then one WR with `mem_write_data`=0x1122AA44, `done` at cycle 3.
- Range/illegal:
  - LW addr 0xFA4 (word 1001) → `err`=1 in 1 cycle, no strobes.
  - store funct3 011 → `err`=1.
- Misalign: LW addr 0x11.
  - With `LSU_MISALIGN_TRAP_EN` → `err`=1, no `mem_memread`.
  - Without → `rdata` = word 4, `err`=0.
- Reset mid-RMW: assert `rst_n`=0 during RD of an SH → strobes low immediately, `ready`=1 after release, memory word unchanged.
